// File: rtl/fdiv_share_pkg.sv
// Shared types and constants for the fdiv sharing controller.
// The optional FDIV_SHARE_RESP_REG_EN macro is consumed by fdiv_share_ctrl.
package fdiv_share_pkg;

   localparam int FLOAT_W          = 32;
   localparam int FDIV_LAT_DEFAULT = 6;
   // Tag field is sized for the largest supported requester count (8).
   localparam int SLOT_TAG_W       = 3;

   typedef logic [FLOAT_W-1:0] float_t;

   typedef struct packed {
      logic                  valid;
      logic [SLOT_TAG_W-1:0] tag;
   } slot_t;

endpackage

// File: rtl/fdiv_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched circularly from
// a pointer that moves just past the winner on every accepted request.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [IDX_W-1:0] ptr;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(ptr) + k) % N;
         if (!grant_any && req[j]) begin
            grant_any = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
      // No grant may be offered while the block is held in reset.
      if (rst) begin
         grant     = '0;
         grant_any = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (grant_any)
         ptr <= (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/fdiv_share_ctrl.sv
// Shares one fixed-latency pipelined fdiv between N_REQ requesters with a
// valid/tag shadow pipeline; FDIV_SHARE_RESP_REG_EN adds a response register.
module fdiv_share_ctrl
   import fdiv_share_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int FDIV_LAT = FDIV_LAT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*FLOAT_W-1:0] req_x1,
   input  logic [N_REQ*FLOAT_W-1:0] req_x2,
   output float_t                   fdiv_x1,
   output float_t                   fdiv_x2,
   input  float_t                   fdiv_y,
   output logic [N_REQ-1:0]         resp_valid,
   output float_t                   resp_y
);

   localparam int TAG_W = $clog2(N_REQ);

   logic [TAG_W-1:0] grant_idx;
   logic             hs;
   float_t           x1_sel;
   float_t           x2_sel;
   slot_t            slot_p0;
   slot_t            shadow_p1 [FDIV_LAT];
   slot_t            slot_last;
   logic [N_REQ-1:0] resp_oh;

   function automatic logic [N_REQ-1:0] tag_onehot(input logic [SLOT_TAG_W-1:0] t);
      tag_onehot = '0;
      for (int i = 0; i < N_REQ; i++)
         tag_onehot[i] = (t == SLOT_TAG_W'(i));
   endfunction

   rr_arbiter #(.N(N_REQ), .IDX_W(TAG_W)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .grant     (req_ready),
      .grant_idx (grant_idx),
      .grant_any (hs)
   );

   assign x1_sel = req_x1[grant_idx*FLOAT_W +: FLOAT_W];
   assign x2_sel = req_x2[grant_idx*FLOAT_W +: FLOAT_W];

   // Stage p0: operands launched into fdiv, issue slot registered alongside.
   // Stages p1..: shadow slots shift unconditionally, last one meets fdiv_y.
   always_ff @(posedge clk) begin
      if (rst) begin
         fdiv_x1 <= '0;
         fdiv_x2 <= '0;
         slot_p0 <= '0;
         for (int k = 0; k < FDIV_LAT; k++)
            shadow_p1[k] <= '0;
      end else begin
         if (hs) begin
            fdiv_x1 <= x1_sel;
            fdiv_x2 <= x2_sel;
         end
         slot_p0.valid <= hs;
         slot_p0.tag   <= SLOT_TAG_W'(grant_idx);
         shadow_p1[0]  <= slot_p0;
         for (int k = 1; k < FDIV_LAT; k++)
            shadow_p1[k] <= shadow_p1[k-1];
      end
   end

   assign slot_last = shadow_p1[FDIV_LAT-1];
   assign resp_oh   = slot_last.valid ? tag_onehot(slot_last.tag) : '0;

`ifdef FDIV_SHARE_RESP_REG_EN
   // Output stage: registered response, quotient held between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= '0;
         resp_y     <= '0;
      end else begin
         resp_valid <= resp_oh;
         if (|resp_oh)
            resp_y <= fdiv_y;
      end
   end
`else
   assign resp_valid = resp_oh;
   assign resp_y     = fdiv_y;
`endif

endmodule

// File: tb/tb_fdiv_share_ctrl.sv
// Scoreboard bench for fdiv_share_ctrl with a behavioural pipelined fdiv.
// Honours FDIV_SHARE_RESP_REG_EN for the expected response latency.
module tb_fdiv_share_ctrl;
   import fdiv_share_pkg::*;

   localparam int N   = 4;
   localparam int LAT = 6;
`ifdef FDIV_SHARE_RESP_REG_EN
   localparam int RESP_LAT = LAT + 2;
`else
   localparam int RESP_LAT = LAT + 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_x1;
   logic [N*32-1:0] req_x2;
   logic [31:0]     fdiv_x1, fdiv_x2, fdiv_y;
   logic [N-1:0]    resp_valid;
   logic [31:0]     resp_y;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int resp_cnt = 0;
   logic [31:0] last_resp_y = '0;

   typedef struct {
      int          tag;
      logic [31:0] y;
      int          due;
   } exp_t;
   exp_t sb[$];
   int   grant_log[$];

   always #5 clk = ~clk;

   fdiv_share_ctrl #(.N_REQ(N), .FDIV_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x1     (req_x1),
      .req_x2     (req_x2),
      .fdiv_x1    (fdiv_x1),
      .fdiv_x2    (fdiv_x2),
      .fdiv_y     (fdiv_y),
      .resp_valid (resp_valid),
      .resp_y     (resp_y)
   );

   function automatic real sp2r(input logic [31:0] a);
      real m;
      int  e;
      if (a[30:23] == 8'd0) return 0.0;
      m = 1.0 + $itor(a[22:0]) / 8388608.0;
      e = int'(a[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return a[31] ? -m : m;
   endfunction

   function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
      real         q;
      logic [63:0] d;
      logic [10:0] ex;
      if (b[30:23] == 8'd0) return 32'h7FC00000;
      q = sp2r(a) / sp2r(b);
      if (q == 0.0) return 32'h0;
      d  = $realtobits(q);
      ex = d[62:52] - 11'd896;
      return {d[63], ex[7:0], d[51:29]};
   endfunction

   function automatic logic [N-1:0] oh(input int t);
      oh = '0;
      oh[t] = 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Behavioural fdiv: result appears LAT edges after its operands change.
   logic [31:0] fpipe [LAT];
   always @(posedge clk) begin
      fpipe[0] <= fp_div(fdiv_x1, fdiv_x2);
      for (int k = 1; k < LAT; k++)
         fpipe[k] <= fpipe[k-1];
   end
   assign fdiv_y = fpipe[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (resp_valid != '0) begin
            resp_cnt++;
            last_resp_y = resp_y;
            if (sb.size() == 0) begin
               chk("spurious_resp", 64'(resp_valid), 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("resp_valid", 64'(resp_valid), 64'(oh(e.tag)));
               chk("resp_y", 64'(resp_y), 64'(e.y));
               chk("resp_cycle", 64'(cyc), 64'(e.due));
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("resp_missing", 64'(resp_valid), 64'(oh(sb[0].tag)));
            void'(sb.pop_front());
         end
         if (req_ready != '0)
            chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               exp_t e;
               e.tag = i;
               e.y   = fp_div(req_x1[32*i +: 32], req_x2[32*i +: 32]);
               e.due = cyc + RESP_LAT;
               sb.push_back(e);
               grant_log.push_back(i);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_x1[32*i +: 32] = a;
      req_x2[32*i +: 32] = b;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int base;
      rst       = 1'b1;
      req_valid = '1;
      req_x1    = '0;
      req_x2    = '0;

      // Reset state
      tick();
      chk("rst_ready_forced_0", 64'(req_ready), 64'd0);
      tick();
      rst       = 1'b0;
      req_valid = '0;
      chk("rst_fdiv_x1", 64'(fdiv_x1), 64'd0);
      chk("rst_fdiv_x2", 64'(fdiv_x2), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);

      // 1: single request from requester 2, 6.0 / 2.0
      do_reset();
      base = resp_cnt;
      set_op(2, 32'h40C00000, 32'h40000000);
      req_valid = 4'b0100;
      #1;
      chk("t1_ready", 64'(req_ready), 64'b0100);
      tick();
      req_valid = '0;
      repeat (RESP_LAT + 4) tick();
      chk("t1_count", 64'(resp_cnt - base), 64'd1);
      chk("t1_y", 64'(last_resp_y), 64'h40400000);

      // 2: all requesters continuously valid, grants rotate
      do_reset();
      grant_log.delete();
      base = resp_cnt;
      set_op(0, 32'h3F800000, 32'h3F800000);
      set_op(1, 32'h3F800000, 32'h40000000);
      set_op(2, 32'h3F800000, 32'h40800000);
      set_op(3, 32'h3F800000, 32'h41000000);
      req_valid = '1;
      repeat (8) tick();
      req_valid = '0;
      repeat (RESP_LAT + 4) tick();
      chk("t2_grants", 64'(grant_log.size()), 64'd8);
      for (int k = 0; k < grant_log.size(); k++)
         chk("t2_grant_order", 64'(grant_log[k]), 64'(k % N));
      chk("t2_count", 64'(resp_cnt - base), 64'd8);

      // 3: requester 1 streams 10 back-to-back pairs
      do_reset();
      base = resp_cnt;
      for (int k = 0; k < 10; k++) begin
         set_op(1, 32'h3F800000 + (32'(k) << 23), 32'h40000000);
         req_valid = 4'b0010;
         #1;
         chk("t3_ready", 64'(req_ready[1]), 64'd1);
         tick();
      end
      req_valid = '0;
      repeat (RESP_LAT + 4) tick();
      chk("t3_count", 64'(resp_cnt - base), 64'd10);

      // 4: pointer wrap 3 -> 0, then back to 3
      do_reset();
      grant_log.delete();
      set_op(0, 32'h41200000, 32'h40A00000);
      set_op(3, 32'h41000000, 32'h40800000);
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b1001;
      tick();
      tick();
      req_valid = '0;
      repeat (RESP_LAT + 4) tick();
      chk("t4_grants", 64'(grant_log.size()), 64'd3);
      if (grant_log.size() == 3) begin
         chk("t4_first", 64'(grant_log[0]), 64'd3);
         chk("t4_wrap", 64'(grant_log[1]), 64'd0);
         chk("t4_after_wrap", 64'(grant_log[2]), 64'd3);
      end

      // 5: reset while three requests are in flight
      do_reset();
      set_op(0, 32'h41400000, 32'h40400000);
      req_valid = 4'b0001;
      repeat (3) tick();
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      base = resp_cnt;
      chk("t5_fdiv_x1_cleared", 64'(fdiv_x1), 64'd0);
      chk("t5_resp_after_rst", 64'(resp_valid), 64'd0);
      repeat (10) tick();
      chk("t5_no_stale", 64'(resp_cnt - base), 64'd0);
      set_op(3, 32'h42C80000, 32'h41200000);
      req_valid = 4'b1000;
      #1;
      chk("t5_first_grant", 64'(req_ready), 64'b1000);
      tick();
      req_valid = '0;
      repeat (RESP_LAT + 4) tick();
      chk("t5_count", 64'(resp_cnt - base), 64'd1);
      chk("t5_y", 64'(last_resp_y), 64'h41200000);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
